line_buffer_ctrl: RTL

LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

---
 rtl/line_buffer_ctrl_pkg.sv | 22 ++
 rtl/line_buffer_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/line_buffer_ctrl_pkg.sv
// Shared vision package for the line buffer controller.
//   lbc_state_t : controller FSM states.
//   DEF_*       : default image geometry, used as parameter defaults.
//   cnt_w()     : width of a counter that spans 0..n-1, never below one bit.
package line_buffer_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } lbc_state_t;

   localparam int DEF_IMAGE_WIDTH  = 640;
   localparam int DEF_IMAGE_HEIGHT = 480;
   localparam int DEF_NUM_LINES    = 2;

   function automatic int cnt_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/line_buffer_ctrl.sv
// Line buffer controller: frames an upstream pixel stream, feeds the line
// buffer and tracks the position of the pixel at the line buffer outputs.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready   : upstream handshake; s_data pixel, s_sof first pixel
//   m_ready           : downstream window consumer can accept
//   lb_pixel/lb_valid : pixel write into the line buffer (combinational)
//   col, row          : position of the pixel now at the line buffer outputs
//   win_valid         : a full vertical column of NUM_LINES+1 pixels is present
//   frame_done        : one-cycle pulse after the last pixel of a frame
//   sof_err           : one-cycle pulse on an s_sof that restarts a frame
module line_buffer_ctrl
   import line_buffer_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
   parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
   parameter int NUM_LINES    = DEF_NUM_LINES
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [DATA_WIDTH-1:0]          s_data,
   input  logic                           s_sof,
   input  logic                           m_ready,
   output logic [DATA_WIDTH-1:0]          lb_pixel,
   output logic                           lb_valid,
   output logic [cnt_w(IMAGE_WIDTH)-1:0]  col,
   output logic [cnt_w(IMAGE_HEIGHT)-1:0] row,
   output logic                           win_valid,
   output logic                           frame_done,
   output logic                           sof_err
);

   localparam int COL_W = cnt_w(IMAGE_WIDTH);
   localparam int ROW_W = cnt_w(IMAGE_HEIGHT);

   localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMAGE_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMAGE_HEIGHT - 1);
   localparam logic [ROW_W-1:0] STREAM_ROW = ROW_W'(NUM_LINES);
   localparam logic [COL_W-1:0] COL_INC    = COL_W'(1);
   localparam logic [ROW_W-1:0] ROW_INC    = ROW_W'(1);

   lbc_state_t       state_q, state_d;
   logic [COL_W-1:0] col_cnt, col_cnt_d;   // position of the next pixel to forward
   logic [ROW_W-1:0] row_cnt, row_cnt_d;
   logic [COL_W-1:0] pix_col;              // position of the pixel forwarded now
   logic [ROW_W-1:0] pix_row;
   logic             fwd;                  // pixel written into the line buffer
   logic             restart;
   logic             last_pix;

   assign lb_pixel = s_data;
   assign lb_valid = fwd;

   always_comb begin
      state_d   = state_q;
      col_cnt_d = col_cnt;
      row_cnt_d = row_cnt;
      s_ready   = 1'b0;
      fwd       = 1'b0;
      restart   = 1'b0;
      pix_col   = col_cnt;
      pix_row   = row_cnt;
      last_pix  = 1'b0;

      case (state_q)
         // Always ready while idle so stray pixels ahead of a frame drain;
         // only an s_sof pixel is forwarded.
         IDLE: begin
            s_ready = 1'b1;
            fwd     = s_valid & s_sof;
         end
         FILL, STREAM: begin
            s_ready = m_ready;
            fwd     = s_valid & m_ready;
            restart = s_valid & m_ready & s_sof;
         end
         // One dead cycle between frames; nothing is accepted here.
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // An s_sof pixel always becomes pixel (0,0) of a fresh frame, which
      // also wins over completing the current frame.
      if (fwd && s_sof) begin
         pix_col = '0;
         pix_row = '0;
      end

      last_pix = fwd && !s_sof && (pix_col == COL_LAST) && (pix_row == ROW_LAST);

      if (last_pix) begin
         state_d   = DONE;
         col_cnt_d = '0;
         row_cnt_d = '0;
      end else if (fwd) begin
         if (pix_col == COL_LAST) begin
            col_cnt_d = '0;
            row_cnt_d = pix_row + ROW_INC;
         end else begin
            col_cnt_d = pix_col + COL_INC;
            row_cnt_d = pix_row;
         end
         state_d = (row_cnt_d >= STREAM_ROW) ? STREAM : FILL;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         col_cnt <= '0;
         row_cnt <= '0;
      end else begin
         state_q <= state_d;
         col_cnt <= col_cnt_d;
         row_cnt <= row_cnt_d;
      end
   end

   // Position/window flags are registered so they line up with the line
   // buffer's registered outputs one cycle after the write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col        <= '0;
         row        <= '0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         sof_err    <= 1'b0;
      end else begin
         if (fwd) begin
            col <= pix_col;
            row <= pix_row;
         end else if (state_q == DONE) begin
            col <= '0;
            row <= '0;
         end
         win_valid  <= fwd && (pix_row >= STREAM_ROW);
         frame_done <= last_pix;
         sof_err    <= restart;
      end
   end

endmodule
